// File: rtl/dec_lock_ctrl_mopshub.sv
// Word-alignment lock controller for an 8b/10b decoder: hunts with bitslip, then locks.
// Optional DEC_LOCK_ERR_CNT_EN adds a saturating err_cnt output for bad words seen while locked.
module dec_lock_ctrl_mopshub #(
    parameter int COMMA_LOCK_CNT = 4,
    parameter int ERR_UNLOCK_CNT = 4,
    parameter int SLIP_WAIT      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_valid,
    input  logic        ko,
    input  logic        code_err,
    input  logic        disp_err,
    output logic        bitslip,
    output logic        locked,
    output logic        data_valid,
    output logic [1:0]  state
`ifdef DEC_LOCK_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SLIP   = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [3:0] LOCK_N   = 4'(COMMA_LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(ERR_UNLOCK_CNT);
    localparam logic [3:0] WAIT_N   = 4'(SLIP_WAIT);

    logic       qv;
    logic [1:0] state_nxt;
    logic [3:0] good_cnt, good_cnt_nxt;
    logic [3:0] bad_cnt, bad_cnt_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic [3:0] good_inc, bad_inc;
    logic       bitslip_nxt;
    logic       is_bad, is_comma;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign is_bad   = code_err | disp_err;
    assign is_comma = ko & ~is_bad;
    assign good_inc = sat_inc(good_cnt);
    assign bad_inc  = sat_inc(bad_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            qv       <= 1'b0;
            state    <= ST_HUNT;
            good_cnt <= 4'd0;
            bad_cnt  <= 4'd0;
            wait_cnt <= 4'd0;
            bitslip  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            qv       <= word_valid;
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            bad_cnt  <= bad_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            bitslip  <= bitslip_nxt;
            locked   <= (state_nxt == ST_LOCKED);
        end
    end

    // Decoder flags are only meaningful when qv marks them as belonging to a real word
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        bad_cnt_nxt  = bad_cnt;
        wait_cnt_nxt = wait_cnt;
        if (qv) begin
            unique case (state)
                ST_HUNT: begin
                    if (is_bad) begin
                        wait_cnt_nxt = WAIT_N;
                        state_nxt    = ST_SLIP;
                    end else if (is_comma) begin
                        good_cnt_nxt = 4'd1;
                        if (LOCK_N == 4'd1) begin
                            bad_cnt_nxt = 4'd0;
                            state_nxt   = ST_LOCKED;
                        end else begin
                            state_nxt = ST_CHECK;
                        end
                    end
                end
                ST_SLIP: begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt_nxt = 4'd0;
                        state_nxt    = ST_HUNT;
                    end
                end
                ST_CHECK: begin
                    if (is_bad) begin
                        good_cnt_nxt = 4'd0;
                        wait_cnt_nxt = WAIT_N;
                        state_nxt    = ST_SLIP;
                    end else if (is_comma) begin
                        good_cnt_nxt = good_inc;
                        if (good_inc == LOCK_N) begin
                            bad_cnt_nxt = 4'd0;
                            state_nxt   = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (is_bad) begin
                        bad_cnt_nxt = bad_inc;
                        if (bad_inc == UNLOCK_N) begin
                            bad_cnt_nxt  = 4'd0;
                            good_cnt_nxt = 4'd0;
                            state_nxt    = ST_HUNT;
                        end
                    end else begin
                        bad_cnt_nxt = 4'd0;
                    end
                end
            endcase
        end
    end

    // Losing lock never slips; only misaligned words during acquisition do
    always_comb begin
        bitslip_nxt = qv & is_bad & ((state == ST_HUNT) | (state == ST_CHECK));
        data_valid  = qv & (state == ST_LOCKED) & ~code_err;
    end

`ifdef DEC_LOCK_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 16'd0;
        end else if (qv && (state == ST_LOCKED) && is_bad && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dec_lock_ctrl_mopshub.sv
// Bench for dec_lock_ctrl_mopshub: vector table, directed sequences, random vs. model.
// Covers err_cnt too when DEC_LOCK_ERR_CNT_EN is defined.
module tb_dec_lock_ctrl_mopshub;

    logic clk = 1'b0;
    logic rst, word_valid, ko, code_err, disp_err;
    logic bitslip, locked, data_valid;
    logic [1:0] state;
`ifdef DEC_LOCK_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // behavioural reference state
    int m_st, m_good, m_bad, m_wait, m_qv, m_bs, m_err;

    localparam int CL = 4, EU = 4, SW = 3;

    dec_lock_ctrl_mopshub dut (
        .clk(clk), .rst(rst), .word_valid(word_valid), .ko(ko),
        .code_err(code_err), .disp_err(disp_err), .bitslip(bitslip),
        .locked(locked), .data_valid(data_valid), .state(state)
`ifdef DEC_LOCK_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input int r, input int wv, input int k, input int c, input int d);
        int bad, comma;
        m_bs = 0;
        if (r != 0) begin
            m_st = 0; m_good = 0; m_bad = 0; m_wait = 0; m_qv = 0; m_err = 0;
            return;
        end
        if (m_qv != 0) begin
            bad   = (c != 0 || d != 0) ? 1 : 0;
            comma = (k != 0 && bad == 0) ? 1 : 0;
            if (m_st == 3 && bad != 0 && m_err < 65535) m_err++;
            case (m_st)
                0: if (bad != 0) begin
                       m_bs = 1; m_wait = SW; m_st = 1;
                   end else if (comma != 0) begin
                       m_good = 1; m_st = (CL == 1) ? 3 : 2; m_bad = 0;
                   end
                1: begin
                       m_wait--;
                       if (m_wait <= 0) begin m_wait = 0; m_st = 0; end
                   end
                2: if (bad != 0) begin
                       m_bs = 1; m_wait = SW; m_good = 0; m_st = 1;
                   end else if (comma != 0) begin
                       m_good = (m_good < 15) ? m_good + 1 : 15;
                       if (m_good == CL) begin m_st = 3; m_bad = 0; end
                   end
                default: if (bad != 0) begin
                       m_bad = (m_bad < 15) ? m_bad + 1 : 15;
                       if (m_bad == EU) begin m_bad = 0; m_st = 0; end
                   end else m_bad = 0;
            endcase
        end
        m_qv = wv;
    endtask

    // one cycle: drive at negedge, check comb output, clock, check registers
    task automatic step(input logic r, input logic wv, input logic k,
                        input logic c, input logic d, output logic dv_s);
        int exp_dv;
        rst = r; word_valid = wv; ko = k; code_err = c; disp_err = d;
        #1;
        exp_dv = (m_qv != 0 && m_st == 3 && c == 1'b0) ? 1 : 0;
        dv_s = data_valid;
        chk("data_valid", int'(data_valid), exp_dv);
        @(posedge clk);
        model(r, wv, k, c, d);
        @(negedge clk);
        chk("state", int'(state), m_st);
        chk("locked", int'(locked), (m_st == 3) ? 1 : 0);
        chk("bitslip", int'(bitslip), m_bs);
`ifdef DEC_LOCK_ERR_CNT_EN
        chk("err_cnt", int'(err_cnt), m_err);
`endif
    endtask

    typedef struct {
        logic r, wv, k, c, d;
        int   dv, st, lk, bs;
    } vec_t;

    vec_t vt[14];
    logic dv;
    int   st_seq[4];

    task automatic go_check2();
        step(1, 0, 0, 0, 0, dv);
        step(0, 1, 0, 0, 0, dv);
        step(0, 1, 1, 0, 0, dv);
        step(0, 1, 1, 0, 0, dv);
    endtask

    initial begin
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 1, 0, 0, 0, 2, 0, 0};
        vt[3]  = '{0, 1, 1, 0, 0, 0, 2, 0, 0};
        vt[4]  = '{0, 1, 1, 0, 0, 0, 2, 0, 0};
        vt[5]  = '{0, 1, 1, 0, 0, 0, 3, 1, 0};
        vt[6]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
        vt[7]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[8]  = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
        vt[9]  = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
        vt[10] = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
        vt[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

        rst = 1; word_valid = 0; ko = 0; code_err = 0; disp_err = 0;
        @(posedge clk);
        model(1, 0, 0, 0, 0);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            step(vt[i].r, vt[i].wv, vt[i].k, vt[i].c, vt[i].d, dv);
            chk($sformatf("vec%0d_dv", i), int'(dv), vt[i].dv);
            chk($sformatf("vec%0d_state", i), int'(state), vt[i].st);
            chk($sformatf("vec%0d_locked", i), int'(locked), vt[i].lk);
            chk($sformatf("vec%0d_bitslip", i), int'(bitslip), vt[i].bs);
        end

        // lock, then error bursts below and at the unlock threshold
        go_check2();
        step(0, 1, 1, 0, 0, dv);
        step(0, 1, 1, 0, 0, dv);
        chk("lock_state", int'(state), 3);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, dv);
        step(0, 1, 0, 0, 0, dv);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, dv);
        chk("hold_lock_state", int'(state), 3);
        chk("hold_lock_locked", int'(locked), 1);
        step(0, 1, 0, 1, 0, dv);
        chk("unlock_state", int'(state), 0);
        chk("unlock_locked", int'(locked), 0);
        chk("unlock_no_slip", int'(bitslip), 0);

        // disparity error during CHECK
        go_check2();
        chk("check_state", int'(state), 2);
        step(0, 1, 0, 0, 1, dv);
        chk("check_err_state", int'(state), 1);
        chk("check_err_slip", int'(bitslip), 1);

        // reset while a bitslip would otherwise be issued mid-CHECK
        go_check2();
        step(1, 1, 0, 1, 0, dv);
        chk("rst_state", int'(state), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_slip", int'(bitslip), 0);
        step(0, 1, 0, 0, 0, dv);
        chk("rst_dv", int'(dv), 0);

        // gapped stream: one word every three cycles, garbage flags when unqualified
        step(1, 0, 0, 0, 0, dv);
        for (int w = 0; w < 4; w++) begin
            step(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), dv);
            step(0, 0, 1, 0, 0, dv);
            st_seq[w] = int'(state);
            step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), dv);
        end
        chk("gap_seq0", st_seq[0], 2);
        chk("gap_seq1", st_seq[1], 2);
        chk("gap_seq2", st_seq[2], 2);
        chk("gap_seq3", st_seq[3], 3);

        // random traffic against the reference model
        step(1, 0, 0, 0, 0, dv);
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) == 0), dv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dec_lock_ctrl_mopshub.md
DEC_LOCK_CTRL_MOPSHUB -- requirements
Module: dec_lock_ctrl_mopshub

Interface
REQ-001 SHALL have parameter COMMA_LOCK_CNT, default 4: error-free commas required in CHECK to enter LOCKED (range 1..15).
REQ-002 SHALL have parameter ERR_UNLOCK_CNT, default 4: consecutive error words in LOCKED that force return to HUNT (range 1..15).
REQ-003 SHALL have parameter SLIP_WAIT, default 3: valid words ignored after each bitslip (range 1..15).
REQ-004 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- word_valid  input  1  raw 10-bit word presented to decoder this cycle; same signal drives the decoder's datain_valid.
- ko  input  1  decoder comma flag, registered.
- code_err  input  1  decoder code error flag, registered.
- disp_err  input  1  decoder disparity error flag, registered.
- bitslip  output  1  one-cycle request to deserializer to shift word boundary by one bit.
- locked  output  1  word alignment established.
- data_valid  output  1  current decoder output is valid aligned data.
- state  output  2  FSM state: 0 HUNT, 1 SLIP_WAIT, 2 CHECK, 3 LOCKED.

Function
REQ-005 SHALL register word_valid once into qv; qv qualifies ko/code_err/disp_err, matching the decoder's one-cycle output latency.
REQ-006 A qualified word SHALL be "bad" when code_err|disp_err, "comma" when ko & !bad, otherwise "data"; ko with error counts as bad.
REQ-007 FSM SHALL advance only on cycles with qv=1; with qv=0 all state and counters hold.
REQ-008 HUNT: bad -> pulse bitslip, load wait_cnt=SLIP_WAIT, go SLIP_WAIT; comma -> good_cnt=1, go CHECK (if COMMA_LOCK_CNT=1 go LOCKED directly); data -> stay.
REQ-009 SLIP_WAIT: each qv decrements wait_cnt, decoder flags ignored; at wait_cnt reaching 0 go HUNT.
REQ-010 CHECK: bad -> bitslip pulse, go SLIP_WAIT, good_cnt=0; comma -> good_cnt+1, go LOCKED when new count equals COMMA_LOCK_CNT; data -> stay, count held.
REQ-011 LOCKED: bad -> bad_cnt+1, go HUNT with bad_cnt=0 when new count equals ERR_UNLOCK_CNT; comma or data -> bad_cnt=0.
REQ-012 bitslip SHALL be high exactly one clk cycle, the cycle after the bad word is qualified; never two pulses closer than SLIP_WAIT+1 qualified words.
REQ-013 locked SHALL be registered and equal (state==LOCKED); asserted the cycle after the final good comma, deasserted the cycle after the unlocking bad word.
REQ-014 data_valid SHALL equal qv & (state==LOCKED) & !code_err, combinational from registers; disp_err alone does not suppress it.
REQ-015 Counters SHALL be 4 bits and never wrap: good_cnt, bad_cnt saturate at 15.
REQ-016 Leaving LOCKED SHALL not issue bitslip; realignment begins only on the next bad word in HUNT.

Reset
REQ-017 When rst=1 at a clk edge: state=HUNT, good_cnt=bad_cnt=wait_cnt=0, qv=0, bitslip=0, locked=0, data_valid=0.
REQ-018 rst SHALL take priority over any simultaneous qv, including mid-SLIP_WAIT or while bitslip would be issued; no bitslip in the cycle after reset.

Configuration
REQ-019 Macro DEC_LOCK_ERR_CNT_EN SHALL, when defined, add output err_cnt (16 bits): count of bad qualified words while LOCKED, saturating at 0xFFFF, cleared by rst only, preserved across loss of lock.
REQ-020 Without DEC_LOCK_ERR_CNT_EN the port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-021 Reset, then 4 qualified error-free commas -> state 0->2->2->2->3, locked=1 one cycle after 4th comma, no bitslip.
REQ-022 In HUNT, one word with code_err=1 -> single bitslip pulse, state=1 for 3 qualified words, then state=0; a bad word during wait -> no extra pulse.
REQ-023 LOCKED, 3 bad words, 1 good, 3 bad -> stays LOCKED; 4 consecutive bad -> locked=0, state=0, no bitslip.
REQ-024 CHECK after 2 commas, then disp_err word -> bitslip pulse, good_cnt=0, state=1; data_valid stays 0 throughout.
REQ-025 word_valid gapped (1 of 3 cycles) -> identical state sequence as continuous stream; rst asserted mid-CHECK -> all outputs 0 next cycle.
REQ-026 With DEC_LOCK_ERR_CNT_EN, 5 bad words in LOCKED (ERR_UNLOCK_CNT=15) -> err_cnt=5; preload near 0xFFFF -> holds 0xFFFF.
